// File: rtl/types_pkg.sv
// Shared types for the experiment top level: the rig-side signal bus, the
// scenario FSM output bus, and the rig emulator parameter and fault types.
package types_pkg;

  // Rig signals presented to the scenario FSM.
  typedef struct packed {
    logic       start;
    logic       fg_opto;
    logic       wire_sensor;
    logic       phase;
    logic       detector_ready;
    logic       emergency_stop;
    logic [1:0] spare;
  } input_signals_t;

  // Scenario FSM outputs toward the rig.
  typedef struct packed {
    logic [7:0] scenario_state;
    logic       fg_open;
    logic       detonator_triggered;
    logic       output_trigger;
    logic       busy;
  } output_signals_t;

  // Run-time timing parameters for the rig emulator, all in clock cycles.
  typedef struct packed {
    logic [31:0] FG_OPTO_DELAY;
    logic [31:0] WIRE_DELAY;
    logic [31:0] PHASE_PERIOD;
    logic [31:0] PHASE_HIGH;
    logic [31:0] DETECTOR_BUSY_LEN;
  } emu_parameters_t;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    NO_DETONATE = 2'd1,
    NO_TRIGGER  = 2'd2
  } emu_fault_t;

  // Sequencer state encoding; every 3-bit code is assigned.
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FG_DELAY   = 3'd1;
  localparam logic [2:0] S_WAIT_DET   = 3'd2;
  localparam logic [2:0] S_WIRE_DELAY = 3'd3;
  localparam logic [2:0] S_WAIT_TRIG  = 3'd4;
  localparam logic [2:0] S_DET_BUSY   = 3'd5;
  localparam logic [2:0] S_HOLD       = 3'd6;
  localparam logic [2:0] S_FAULT      = 3'd7;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/phase_generator.sv
// Free-running phase square wave: high for the first phase_high counts of
// every phase_period-count cycle. Period 0 parks the output low.
module phase_generator (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] phase_period,
  input  logic [31:0] phase_high,
  output logic        phase
);

  logic [31:0] count;
  logic [31:0] count_next;

  // Next count; a restart on count >= period-1 means a period shrunk at
  // run time below the current count wraps at once instead of overrunning.
  always_comb begin
    count_next = '0;
    if (phase_period == 32'd0) begin
      count_next = '0;
    end else if (count >= phase_period - 32'd1) begin
      count_next = '0;
    end else begin
      count_next = count + 32'd1;
    end
  end

  // Counter and registered phase; phase tracks the count it is paired with.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      phase <= 1'b0;
    end else begin
      count <= count_next;
      phase <= (phase_period != 32'd0) && (count_next < phase_high);
    end
  end

endmodule

// File: rtl/rig_emulator.sv
// Hardware-in-the-loop stand-in for the experiment rig. Plays the rig side of
// a shot (start, fg_opto, wire_sensor, phase, detector_ready) into the
// scenario FSM and times its detonator and output_trigger responses.
module rig_emulator
  import types_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter logic [31:0] TIMEOUT   = 32'd100_000_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fire,
  input  emu_parameters_t par,
  input  output_signals_t in,
  output input_signals_t  out,
  output logic [7:0]      emu_state,
  output emu_fault_t      fault,
  output logic            done,
  output logic [31:0]     meas_fg_to_det,
  output logic [31:0]     meas_det_len,
  output logic [31:0]     meas_wire_to_trig,
  output logic [15:0]     shot_count
);

  // Pulses are at least one cycle wide even if PULSE_LEN is set to 0.
  localparam logic [31:0] PULSE_M1 = (PULSE_LEN > 1) ? 32'(PULSE_LEN - 1) : 32'd0;

  logic [1:0]  fire_h;
  logic [1:0]  det_h;
  logic [1:0]  trig_h;
  logic        fire_edge;
  logic        det_edge;
  logic        trig_edge;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [31:0] elapsed;
  logic [31:0] busy_len;
  logic [31:0] fg_pulse_cnt;
  logic [31:0] wire_pulse_cnt;
  logic        start_r;
  logic        fg_r;
  logic        wire_r;
  logic        ready_r;
  logic        phase;
  logic        det_len_active;
  logic        shot_begin;
  logic        unused_in;

  // Only the detonator and trigger fields of the FSM bus matter here.
  assign unused_in = ^{in.scenario_state, in.fg_open, in.busy};

  // An edge is a 0 followed by a 1 in the two-sample history.
  assign fire_edge  = (fire_h == 2'b01);
  assign det_edge   = (det_h  == 2'b01);
  assign trig_edge  = (trig_h == 2'b01);
  assign elapsed    = sat_inc(cnt);
  assign busy_len   = (par.DETECTOR_BUSY_LEN == 32'd0) ? 32'd1 : par.DETECTOR_BUSY_LEN;
  assign shot_begin = (state == S_IDLE) && fire_edge;

  // Two-deep sample history for the operator request and FSM responses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fire_h <= 2'b00;
      det_h  <= 2'b00;
      trig_h <= 2'b00;
    end else begin
      fire_h <= {fire_h[0], fire};
      det_h  <= {det_h[0], in.detonator_triggered};
      trig_h <= {trig_h[0], in.output_trigger};
    end
  end

  phase_generator u_phase_generator (
    .clock        (clock),
    .reset        (reset),
    .phase_period (par.PHASE_PERIOD),
    .phase_high   (par.PHASE_HIGH),
    .phase        (phase)
  );

  // Shot sequencer: walks one shot, owns the rig outputs, timeouts and the
  // two latency measurements. cnt is reused as the per-state cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      start_r           <= 1'b0;
      fg_r              <= 1'b0;
      wire_r            <= 1'b0;
      fg_pulse_cnt      <= '0;
      wire_pulse_cnt    <= '0;
      ready_r           <= 1'b1;
      fault             <= NONE;
      done              <= 1'b0;
      meas_fg_to_det    <= '0;
      meas_wire_to_trig <= '0;
      shot_count        <= '0;
    end else begin
      done <= 1'b0;

      // Pulse timers run on their own so a state change cannot cut a pulse.
      if (fg_r) begin
        if (fg_pulse_cnt == 32'd0) fg_r <= 1'b0;
        else                       fg_pulse_cnt <= fg_pulse_cnt - 32'd1;
      end
      if (wire_r) begin
        if (wire_pulse_cnt == 32'd0) wire_r <= 1'b0;
        else                         wire_pulse_cnt <= wire_pulse_cnt - 32'd1;
      end

      case (state)
        S_IDLE: begin
          if (fire_edge) begin
            start_r           <= 1'b1;
            cnt               <= '0;
            meas_fg_to_det    <= '0;
            meas_wire_to_trig <= '0;
            fault             <= NONE;
            state             <= S_FG_DELAY;
          end
        end

        S_FG_DELAY: begin
          if (cnt >= par.FG_OPTO_DELAY) begin
            fg_r         <= 1'b1;
            fg_pulse_cnt <= PULSE_M1;
            cnt          <= '0;
            state        <= S_WAIT_DET;
          end else begin
            cnt <= elapsed;
          end
        end

        S_WAIT_DET: begin
          // The edge wins over a coincident timeout.
          if (det_edge) begin
            meas_fg_to_det <= elapsed;
            cnt            <= '0;
            state          <= S_WIRE_DELAY;
          end else if (elapsed >= TIMEOUT) begin
            fault   <= NO_DETONATE;
            start_r <= 1'b0;
            fg_r    <= 1'b0;
            wire_r  <= 1'b0;
            ready_r <= 1'b1;
            state   <= S_FAULT;
          end else begin
            cnt <= elapsed;
          end
        end

        S_WIRE_DELAY: begin
          if (cnt >= par.WIRE_DELAY) begin
            wire_r         <= 1'b1;
            wire_pulse_cnt <= PULSE_M1;
            cnt            <= '0;
            state          <= S_WAIT_TRIG;
          end else begin
            cnt <= elapsed;
          end
        end

        S_WAIT_TRIG: begin
          if (trig_edge) begin
            meas_wire_to_trig <= elapsed;
            ready_r           <= 1'b0;
            cnt               <= '0;
            state             <= S_DET_BUSY;
          end else if (elapsed >= TIMEOUT) begin
            fault   <= NO_TRIGGER;
            start_r <= 1'b0;
            fg_r    <= 1'b0;
            wire_r  <= 1'b0;
            ready_r <= 1'b1;
            state   <= S_FAULT;
          end else begin
            cnt <= elapsed;
          end
        end

        S_DET_BUSY: begin
          if (elapsed >= busy_len) begin
            ready_r <= 1'b1;
            cnt     <= '0;
            state   <= S_HOLD;
          end else begin
            cnt <= elapsed;
          end
        end

        S_HOLD: begin
          // The shot only completes once the operator lets go of fire.
          if (!fire_h[0]) begin
            start_r    <= 1'b0;
            done       <= 1'b1;
            shot_count <= shot_count + 16'd1;
            state      <= S_IDLE;
          end
        end

        S_FAULT: begin
          start_r <= 1'b0;
          fg_r    <= 1'b0;
          wire_r  <= 1'b0;
          ready_r <= 1'b1;
          if (!fire_h[0]) state <= S_IDLE;
        end

        default: begin
          start_r <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Detonator high time: counts from the detected edge while the sampled
  // level stays high, regardless of where the sequencer is.
  always_ff @(posedge clock) begin
    if (!reset) begin
      meas_det_len   <= '0;
      det_len_active <= 1'b0;
    end else if (shot_begin) begin
      meas_det_len   <= '0;
      det_len_active <= 1'b0;
    end else if (det_edge) begin
      meas_det_len   <= 32'd1;
      det_len_active <= 1'b1;
    end else if (det_len_active) begin
      if (det_h[0]) meas_det_len <= sat_inc(meas_det_len);
      else          det_len_active <= 1'b0;
    end
  end

  // Rig bus assembly; fields the emulator does not own stay 0.
  always_comb begin
    out                = '0;
    out.start          = start_r;
    out.fg_opto        = fg_r;
    out.wire_sensor    = wire_r;
    out.phase          = phase;
    out.detector_ready = ready_r;
  end

  assign emu_state = {5'd0, state};

endmodule

// File: doc/rig_emulator.md
# rig_emulator

- Hardware-in-the-loop stand-in for the physical experiment rig.
- Drives the rig-side signals (start, fg_opto, wire_sensor, phase, detector_ready) into the experiment-phase scenario FSM and responds to its outputs (detonator_triggered, output_trigger).
- Measures the FSM's detonator and trigger timing, so scenarios can be exercised in the lab and in simulation without detonators, wire sensors or a detector.
- Sits beside the scenario FSM in the top level, muxed onto its input bus when emulation is selected.

## Interface
Parameters:
- PULSE_LEN, 4: width in cycles of fg_opto and wire_sensor pulses; minimum 1.
- TIMEOUT, 32'd100_000_000: cycles allowed for each FSM response before fault.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low; 0 = reset
- fire  in  1  operator shot request; level, rising edge starts a shot
- par  in  emu_parameters_t  FG_OPTO_DELAY, WIRE_DELAY, PHASE_PERIOD, PHASE_HIGH, DETECTOR_BUSY_LEN (32 b each)
- in  in  output_signals_t  FSM outputs; only detonator_triggered and output_trigger are used
- out  out  input_signals_t  rig signals to the FSM; start, fg_opto, wire_sensor, phase and detector_ready are driven, all other fields are 0
- emu_state  out  8  current sequencer state, zero-extended
- fault  out  emu_fault_t  NONE, NO_DETONATE or NO_TRIGGER; sticky until the next shot
- done  out  1  one-cycle pulse at shot completion
- meas_fg_to_det  out  32  cycles from fg_opto rise to detonator edge
- meas_det_len  out  32  detonator high time in cycles
- meas_wire_to_trig  out  32  cycles from wire_sensor rise to output_trigger edge
- shot_count  out  16  completed shots; wraps at 16'hFFFF

## Operation
**Input sampling**
- fire, detonator_triggered and output_trigger each pass through a 2-bit history register.
- An edge means history == 2'b01.

**Phase generator (free-running, independent of the sequencer)**
- Counter runs 0..PHASE_PERIOD-1; phase = (count < PHASE_HIGH).
- PHASE_PERIOD == 0: phase held 0, counter held 0.
- PHASE_HIGH >= PHASE_PERIOD: phase constant 1.
- The counter restarts when count >= PHASE_PERIOD-1, so a run-time shrink of the period cannot overrun.

**Sequencer states**
- IDLE: on a fire edge, set start = 1, clear counter and measurements, go to FG_DELAY.
- FG_DELAY: count to FG_OPTO_DELAY, then pulse fg_opto for PULSE_LEN cycles and go to WAIT_DET.
- WAIT_DET: on a detonator edge, latch meas_fg_to_det and go to WIRE_DELAY. If the counter reaches TIMEOUT, set fault = NO_DETONATE and go to FAULT.
- WIRE_DELAY: count to WIRE_DELAY from the detonator edge, then pulse wire_sensor for PULSE_LEN cycles and go to WAIT_TRIG.
- WAIT_TRIG: on an output_trigger edge, latch meas_wire_to_trig, drive detector_ready = 0 and go to DET_BUSY. If the counter reaches TIMEOUT, set fault = NO_TRIGGER and go to FAULT.
- DET_BUSY: hold detector_ready = 0 for max(DETECTOR_BUSY_LEN, 1) cycles, then set detector_ready = 1 and go to HOLD.
- HOLD: start stays 1 until fire is low. Then start = 0, done pulses, shot_count increments, go to IDLE.
- FAULT: force start = 0, fg_opto = 0, wire_sensor = 0, detector_ready = 1. When fire is low, go to IDLE; fault persists until the next fire edge clears it.
- Illegal state: go to IDLE.

**Measurements**
- meas_det_len counts every cycle detonator history[0] = 1 from the detonator edge until it falls, independent of sequencer state.
- All measurement counters saturate at 32'hFFFF_FFFF.
- Measurements are valid once done pulses and are held until the next fire edge.

## Timing
- All outputs are registered.
- Reset values: start 0, fg_opto 0, wire_sensor 0, phase 0, detector_ready 1, fault NONE, done 0, all meas 0, shot_count 0, state IDLE.
- Reset taken mid-shot returns to IDLE immediately, with no done pulse and no fault.
- start rises 2 cycles after fire rises at the pins.
- fg_opto rises FG_OPTO_DELAY+1 cycles after start.
- wire_sensor rises WIRE_DELAY+1 cycles after the detonator edge is detected.
- detector_ready falls 1 cycle after the trigger edge is detected.
- A detonator edge arriving while fg_opto is still high is accepted.
- fire edges outside IDLE are ignored.
- fire dropping mid-shot does not abort the shot; the shot completes through HOLD.

## Structure
- Add to types_pkg: emu_parameters_t (packed struct, five 32-bit fields) and emu_fault_t (logic [1:0] enum: NONE, NO_DETONATE, NO_TRIGGER).
- Sub-module phase_generator: clock, reset, PHASE_PERIOD, PHASE_HIGH -> phase.
- The sequencer and measurement counters live in rig_emulator.

## Test plan
- Loop with the scenario FSM: PHASE_PERIOD=10, PHASE_HIGH=5, FG_OPTO_DELAY=20, FG_OPEN_DELAY=5, DETONATE_LEN=8, WIRE_DELAY=30, PHASE_SHIFT=3, TRIGGER_LEN=4, DETECTOR_BUSY_LEN=50, pulse fire. Required: meas_det_len=8, done=1 once, shot_count=1, both blocks return to IDLE.
- Tie detonator_triggered to 0 with TIMEOUT=1000, fire. Required: fault=NO_DETONATE about 1000 cycles after fg_opto, start=0. Lower fire -> IDLE; next fire clears fault.
- Phase checks: PHASE_PERIOD=0 -> phase constant 0. PHASE_PERIOD=4, PHASE_HIGH=4 -> phase constant 1. Period 10 -> 7 mid-run -> next rise exactly 7 cycles apart with no overrun.
- DETECTOR_BUSY_LEN=0: detector_ready is low for exactly 1 cycle after the trigger edge.
- Assert reset (0) in WIRE_DELAY: the next cycle shows all outputs at reset values and done=0. Deassert, fire -> a normal shot.
- Hold fire high 3 shots long, then low: start stays 1 through HOLD, done pulses once, no retrigger.
